eth_mac_swap: RTL
=================

ETH_MAC_SWAP -- requirements
Module: eth_mac_swap

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 16, width of the frame and runt counters.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx_axis_if  AXIS_IF.Receiver  tdata[7:0], tvalid, tready, tlast, tuser  byte stream from MAC receive path.
REQ-005 SHALL have port tx_axis_if  AXIS_IF.Transmitter  tdata[7:0], tvalid, tready, tlast, tuser  byte stream to MAC transmit path.
REQ-006 SHALL have port frame_count  output  COUNT_WIDTH  frames forwarded since reset.
REQ-007 SHALL have port runt_count  output  COUNT_WIDTH  frames dropped as runts since reset.

Function
REQ-008 SHALL implement states CAPTURE, EMIT, PASS; reset state CAPTURE.
REQ-009 SHALL, in CAPTURE, drive rx tready=1 and tx tvalid=0, and store each accepted byte in header buffer entry idx (0..11), then increment idx.
REQ-010 SHALL transition CAPTURE->EMIT when byte idx=11 is accepted with tlast=0; idx resets to 0.
REQ-011 SHALL, on any CAPTURE byte accepted with tlast=1 (frame of 12 bytes or fewer), discard the buffered bytes, reset idx to 0, stay in CAPTURE, and increment runt_count.
REQ-012 SHALL, in EMIT, drive rx tready=0, tx tvalid=1, tlast=0, tuser=0, and tdata=buf[idx+6] for idx 0..5, buf[idx-6] for idx 6..11 (source MAC first, then destination MAC).
REQ-013 SHALL advance idx in EMIT only on tx handshake (tvalid & tready); hold tdata stable while tready=0.
REQ-014 SHALL transition EMIT->PASS on the handshake of idx=11; idx resets to 0.
REQ-015 SHALL, in PASS, connect combinationally: tx tdata/tvalid/tlast/tuser = rx fields, rx tready = tx tready; no added latency.
REQ-016 SHALL transition PASS->CAPTURE on a handshake with tlast=1 and increment frame_count in that cycle.
REQ-017 SHALL propagate tuser (bad frame flag) only on PASS beats; runt tuser is ignored.
REQ-018 SHALL let counters wrap modulo 2^COUNT_WIDTH.
REQ-019 SHALL never emit a beat in CAPTURE and never accept an rx beat in EMIT.
REQ-020 SHALL add latency of exactly 12 accepted rx bytes before the first tx beat; with tready held high, first tx beat appears the cycle after byte 11 is accepted.
REQ-021 SHALL sustain one byte per cycle in PASS when both sides are continuously ready.

Reset
REQ-022 SHALL, with reset high at a rising edge, set state=CAPTURE, idx=0, frame_count=0, runt_count=0.
REQ-023 SHALL, during and one cycle after reset, drive tx tvalid=0; rx tready follows state (1 in CAPTURE).
REQ-024 SHALL, on reset mid-frame (EMIT or PASS), abandon the frame without emitting tlast; the remainder of the in-flight rx frame is treated as a new frame by CAPTURE.
REQ-025 SHALL not require reset of the header buffer contents.

Verification
REQ-026 SHALL pass: 64-byte frame, dst=01..06, src=0A..0F, tready=1 -> tx bytes 0A..0F,01..06, bytes 12..63 unchanged, tlast on byte 64, frame_count=1.
REQ-027 SHALL pass: 10-byte frame with tlast on byte 10 -> no tx beats, runt_count=1, following 64-byte frame forwarded correctly.
REQ-028 SHALL pass: exactly 12-byte frame -> dropped, runt_count=1; 13-byte frame -> 13 tx beats, tlast on beat 13.
REQ-029 SHALL pass: tx tready toggling 1,0,0,1 pattern throughout a 60-byte frame -> output bytes identical to unstalled case, tdata stable while stalled, no lost or duplicated bytes.
REQ-030 SHALL pass: frame with tuser=1 on final beat -> tx tuser=1 on tlast beat, frame_count incremented.
REQ-031 SHALL pass: reset asserted during PASS at byte 30 -> next cycle state CAPTURE, counters 0, tx tvalid=0; subsequent clean frame forwarded correctly.

Source files
------------

// File: rtl/eth_mac_swap_if.sv
// AXI-Stream byte channel shared by the receive and transmit sides of eth_mac_swap.
interface AXIS_IF;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport Receiver (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );

    modport Transmitter (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );
endinterface

// File: rtl/eth_mac_swap.sv
// Swaps destination and source MAC addresses of each frame; frames of 12 bytes or fewer are
// dropped and counted as runts, all later bytes pass through combinationally.
module eth_mac_swap #(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    AXIS_IF.Receiver               rx_axis_if,
    AXIS_IF.Transmitter            tx_axis_if,
    output logic [COUNT_WIDTH-1:0] frame_count,
    output logic [COUNT_WIDTH-1:0] runt_count
);

    localparam int unsigned HdrLen = 12;
    localparam logic [3:0] IdxLast = 4'd11;
    localparam logic [3:0] MacLen = 4'd6;
    localparam logic [COUNT_WIDTH-1:0] CountOne = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StCapture = 2'd0,
        StEmit    = 2'd1,
        StPass    = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             idx_q, idx_d;
    logic [COUNT_WIDTH-1:0] frame_count_q, frame_count_d;
    logic [COUNT_WIDTH-1:0] runt_count_q, runt_count_d;
    logic [7:0]             hdr_q [HdrLen];
    logic                   hdr_we;
    logic [3:0]             emit_sel;

    // Source MAC (bytes 6..11) goes out first, then destination MAC (bytes 0..5).
    assign emit_sel = (idx_q < MacLen) ? (idx_q + MacLen) : (idx_q - MacLen);

    always_comb begin
        state_d            = state_q;
        idx_d              = idx_q;
        frame_count_d      = frame_count_q;
        runt_count_d       = runt_count_q;
        hdr_we             = 1'b0;
        rx_axis_if.tready  = 1'b0;
        tx_axis_if.tdata   = 8'h00;
        tx_axis_if.tvalid  = 1'b0;
        tx_axis_if.tlast   = 1'b0;
        tx_axis_if.tuser   = 1'b0;

        unique case (state_q)
            StCapture: begin
                rx_axis_if.tready = 1'b1;
                if (rx_axis_if.tvalid) begin
                    hdr_we = 1'b1;
                    if (rx_axis_if.tlast) begin
                        idx_d        = 4'd0;
                        runt_count_d = runt_count_q + CountOne;
                    end else if (idx_q == IdxLast) begin
                        idx_d   = 4'd0;
                        state_d = StEmit;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            StEmit: begin
                tx_axis_if.tvalid = 1'b1;
                tx_axis_if.tdata  = hdr_q[emit_sel];
                if (tx_axis_if.tready) begin
                    if (idx_q == IdxLast) begin
                        idx_d   = 4'd0;
                        state_d = StPass;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            StPass: begin
                tx_axis_if.tdata  = rx_axis_if.tdata;
                tx_axis_if.tvalid = rx_axis_if.tvalid;
                tx_axis_if.tlast  = rx_axis_if.tlast;
                tx_axis_if.tuser  = rx_axis_if.tuser;
                rx_axis_if.tready = tx_axis_if.tready;
                if (rx_axis_if.tvalid && tx_axis_if.tready && rx_axis_if.tlast) begin
                    state_d       = StCapture;
                    frame_count_d = frame_count_q + CountOne;
                end
            end
            default: begin
                state_d = StCapture;
                idx_d   = 4'd0;
            end
        endcase

        // Nothing may leave while reset is held, even if the state register is still mid-frame.
        if (reset) begin
            tx_axis_if.tvalid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StCapture;
            idx_q         <= 4'd0;
            frame_count_q <= '0;
            runt_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            frame_count_q <= frame_count_d;
            runt_count_q  <= runt_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (hdr_we && !reset) begin
            hdr_q[idx_q] <= rx_axis_if.tdata;
        end
    end

    assign frame_count = frame_count_q;
    assign runt_count  = runt_count_q;

endmodule
